pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Controller on the consuming end of the ECP5 PLL. It drives the PLL `RST` input, watches the asynchronous `LOCK` output, and retries the PLL when lock times out. It releases a system reset only after lock has been continuously stable, and re-asserts that reset immediately on loss of lock. It runs on the PLL reference clock (25 MHz), which stays valid whether or not the PLL is locked.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages synchronising `pll_locked`; range 2 or more.
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per reset attempt; range 1 or more.
- `TIMEOUT_CYCLES`, 65536: cycles allowed in WAIT_LOCK before a retry; range 1 or more.
- `STABLE_CYCLES`, 1024: consecutive locked cycles required before the hold phase; range 1 or more.
- `HOLD_CYCLES`, 16: extra cycles `sys_reset` is held after stability is reached; range 1 or more.
- `clk` in 1: 25 MHz PLL reference clock.
- `reset` in 1: asynchronous, active-high.
- `pll_locked` in 1: PLL `LOCK` output; asynchronous to `clk`.
- `pll_rst` out 1: drives PLL `RST`; active-high.
- `sys_reset` out 1: system reset request; consumer domains resynchronise it.
- `ready` out 1: high only in RUN.
- `retry_count` out 8: number of lock timeouts; saturates at 255.
- `lock_loss_count` out 8: number of lock losses from RUN; saturates at 255.
- `state` out 3: debug encoding PLL_RESET=0, WAIT_LOCK=1, STABLE=2, HOLD=3, RUN=4.

## Operation
- `locked_s` is `pll_locked` after `SYNC_STAGES` flops. Only `locked_s` is used internally.
- One shared cycle counter. Width is clog2 of the largest count parameter plus 1. It clears on every state change.
- Every output is a register updated on the same edge as the state register, decoded from the next state:
  - `pll_rst` = 1 only in PLL_RESET.
  - `sys_reset` = 1 in every state except RUN.
  - `ready` = 1 only in RUN.
- **PLL_RESET:** count `RST_CYCLES` cycles, then go to WAIT_LOCK. `locked_s` is ignored in this state.
- **WAIT_LOCK:**
  - If `locked_s`=1, go to STABLE.
  - Otherwise, when the counter reaches `TIMEOUT_CYCLES`-1, go to PLL_RESET and increment `retry_count`.
  - If lock and timeout occur in the same cycle, lock wins and `retry_count` does not change.
- **STABLE:**
  - `locked_s`=0 in any cycle: go to WAIT_LOCK. Neither counter increments.
  - After `STABLE_CYCLES` consecutive cycles with `locked_s`=1, go to HOLD.
  - A drop in the final counting cycle wins over the transition to HOLD.
- **HOLD:**
  - `locked_s`=0: go to WAIT_LOCK. No counter increments.
  - After `HOLD_CYCLES` cycles, go to RUN.
- **RUN:** `locked_s`=0 sends the state to WAIT_LOCK and increments `lock_loss_count`. The PLL is not reset on loss of lock; only a timeout resets it.
- Both event counters saturate at 255 and never wrap. Only `reset` clears them.
- `reset` asserted at any time, including mid-sequence:
  - Next state is PLL_RESET, counter cleared.
  - Synchroniser flops cleared to 0.
  - Both event counters cleared.

## Timing
- Values while `reset` is asserted and on release:
  - `state`=0, `pll_rst`=1, `sys_reset`=1, `ready`=0, `retry_count`=0, `lock_loss_count`=0.
- After `reset` deasserts, `pll_rst` stays high for exactly `RST_CYCLES` rising edges.
- Lock acquisition latency, with `pll_locked` rising before edge E1 and WAIT_LOCK already active:
  - `locked_s`=1 after edge E(`SYNC_STAGES`).
  - STABLE is entered at E(`SYNC_STAGES`+1).
  - HOLD is entered at E(`SYNC_STAGES`+1+`STABLE_CYCLES`).
  - RUN is entered, `ready`=1 and `sys_reset`=0, at E(`SYNC_STAGES`+1+`STABLE_CYCLES`+`HOLD_CYCLES`).
- Loss latency: `pll_locked` falls before E1. At E(`SYNC_STAGES`+1), `sys_reset`=1, `ready`=0 and `lock_loss_count` is incremented.
- Timeout: the retry edge is the `TIMEOUT_CYCLES`-th edge after WAIT_LOCK entry, with `locked_s`=0 on every one of those cycles.
- `pll_locked` pulses shorter than one `clk` period may be missed; this is acceptable.

## Test plan
All scenarios use SYNC=2, RST=4, TIMEOUT=20, STABLE=8, HOLD=4.
- **Reset values:** release `reset` with `pll_locked`=0 -> `pll_rst`=1 for 4 edges, then 0; `state`=1; `sys_reset`=1; `ready`=0; both counts 0.
- **Clean lock:** raise `pll_locked` with WAIT_LOCK active -> `ready` and `sys_reset` change at the 15th edge after the rise, `state`=4; counts stay 0.
- **Timeout retry:** hold `pll_locked`=0 -> after 20 WAIT_LOCK cycles `pll_rst`=1 for 4 cycles and `retry_count`=1. Repeat for 300 timeouts -> `retry_count` stays at 255.
- **Glitch during STABLE:** drop `pll_locked` for 3 cycles after 5 stable cycles -> `state` returns to 1 with `sys_reset` still 1. Re-lock -> the full 8+4 cycles are required again; `lock_loss_count`=0.
- **Loss in RUN:** drop `pll_locked` -> `state`=1, `sys_reset`=1, `ready`=0, `lock_loss_count`=1 on the 3rd edge; `pll_rst` stays 0. Re-lock -> RUN again.
- **Mid-run reset:** assert `reset` in HOLD -> `state`=0, `pll_rst`=1, counts cleared, synchroniser flops cleared, all asynchronously.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//
// Supervises an ECP5 PLL from its reference-clock domain. It pulses the PLL
// reset, waits for LOCK, retries the PLL when lock does not arrive in time,
// and releases the system reset only after lock has stayed stable. The
// system reset is re-asserted as soon as lock is lost.
//
// Parameters:
//   SYNC_STAGES    flops synchronising pll_locked (>= 2)
//   RST_CYCLES     cycles pll_rst is held high per attempt (>= 1)
//   TIMEOUT_CYCLES cycles allowed waiting for lock before a retry (>= 1)
//   STABLE_CYCLES  consecutive locked cycles before the hold phase (>= 1)
//   HOLD_CYCLES    extra cycles sys_reset is held after stability (>= 1)
//
// Ports:
//   clk             PLL reference clock (free-running)
//   reset           asynchronous, active-high
//   pll_locked      PLL LOCK output, asynchronous to clk
//   pll_rst         drives PLL RST, high only in PLL_RESET
//   sys_reset       system reset request, low only in RUN
//   ready           high only in RUN
//   retry_count     lock timeouts seen, saturating at 255
//   lock_loss_count lock losses from RUN, saturating at 255
//   state           debug state: 0 PLL_RESET, 1 WAIT_LOCK, 2 STABLE,
//                   3 HOLD, 4 RUN

module pll_lock_supervisor #(
    parameter int SYNC_STAGES    = 2,
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] retry_count,
    output logic [7:0] lock_loss_count,
    output logic [2:0] state
);

    localparam logic [2:0] S_PLL_RESET = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_HOLD      = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;

    localparam int MAX_AB    = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_CD    = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int MAX_COUNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W     = $clog2(MAX_COUNT) + 1;

    // Counter value on the last cycle of each timed phase.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             next_state;
    logic                   retry_inc;
    logic                   loss_inc;

    // Synchroniser is reset too, so a stale LOCK cannot leak past a reset.
    // NOTE: clocked state is always assigned with <= so every flop samples
    // the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Next-state logic. Loss of lock is checked before the count limit so a
    // drop on the final counting cycle wins over advancing.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        retry_inc  = 1'b0;
        loss_inc   = 1'b0;
        case (state)
            S_PLL_RESET: begin
                if (cnt == RST_LAST) next_state = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    next_state = S_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    next_state = S_PLL_RESET;
                    retry_inc  = 1'b1;
                end
            end
            S_STABLE: begin
                if (!locked_s)                next_state = S_WAIT_LOCK;
                else if (cnt == STABLE_LAST)  next_state = S_HOLD;
            end
            S_HOLD: begin
                if (!locked_s)              next_state = S_WAIT_LOCK;
                else if (cnt == HOLD_LAST)  next_state = S_RUN;
            end
            S_RUN: begin
                // Lock loss does not reset the PLL; only a timeout does.
                if (!locked_s) begin
                    next_state = S_WAIT_LOCK;
                    loss_inc   = 1'b1;
                end
            end
            default: next_state = S_PLL_RESET;
        endcase
    end

    // State, shared counter and outputs. Outputs decode next_state so they
    // change on the same edge as the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_PLL_RESET;
            cnt             <= '0;
            pll_rst         <= 1'b1;
            sys_reset       <= 1'b1;
            ready           <= 1'b0;
            retry_count     <= 8'd0;
            lock_loss_count <= 8'd0;
        end else begin
            state     <= next_state;
            pll_rst   <= (next_state == S_PLL_RESET);
            sys_reset <= (next_state != S_RUN);
            ready     <= (next_state == S_RUN);

            // RUN has no timed exit, so the counter idles there and never wraps.
            if (next_state != state) begin
                cnt <= '0;
            end else if (state != S_RUN) begin
                cnt <= cnt + 1'b1;
            end

            if (retry_inc && (retry_count != 8'hFF)) begin
                retry_count <= retry_count + 8'd1;
            end
            if (loss_inc && (lock_loss_count != 8'hFF)) begin
                lock_loss_count <= lock_loss_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
//
// Self-checking bench for pll_lock_supervisor with SYNC=2, RST=4,
// TIMEOUT=20, STABLE=8, HOLD=4. A phase/duration reference model runs in
// lock-step with the DUT; directed scenarios add fixed expectations.

module tb_pll_lock_supervisor;

    localparam int SYNC    = 2;
    localparam int RSTC    = 4;
    localparam int TIMEOUT = 20;
    localparam int STABLE  = 8;
    localparam int HOLD    = 4;

    logic       clk;
    logic       reset;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic [7:0] retry_count;
    logic [7:0] lock_loss_count;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    pll_lock_supervisor #(
        .SYNC_STAGES    (SYNC),
        .RST_CYCLES     (RSTC),
        .TIMEOUT_CYCLES (TIMEOUT),
        .STABLE_CYCLES  (STABLE),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pll_locked      (pll_locked),
        .pll_rst         (pll_rst),
        .sys_reset       (sys_reset),
        .ready           (ready),
        .retry_count     (retry_count),
        .lock_loss_count (lock_loss_count),
        .state           (state)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // ---------------- reference model ----------------
    typedef enum int {M_RESET = 0, M_WAIT = 1, M_STABLE = 2, M_HOLD = 3, M_RUN = 4} phase_t;

    phase_t m_phase;
    int     m_elapsed;
    int     m_retries;
    int     m_losses;
    bit     m_hist[$];

    task automatic model_reset();
        m_phase   = M_RESET;
        m_elapsed = 0;
        m_retries = 0;
        m_losses  = 0;
        m_hist    = {};
        for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    endtask

    task automatic model_goto(input phase_t p);
        m_phase   = p;
        m_elapsed = 0;
    endtask

    // One rising edge; lk is the pll_locked level at that edge.
    task automatic model_step(input bit lk);
        bit ls;
        bit last;
        ls = m_hist[SYNC-1];
        m_hist.push_front(lk);
        void'(m_hist.pop_back());
        case (m_phase)
            M_RESET:  last = (m_elapsed + 1 == RSTC);
            M_WAIT:   last = (m_elapsed + 1 == TIMEOUT);
            M_STABLE: last = (m_elapsed + 1 == STABLE);
            M_HOLD:   last = (m_elapsed + 1 == HOLD);
            default:  last = 1'b0;
        endcase
        case (m_phase)
            M_RESET: if (last) model_goto(M_WAIT); else m_elapsed++;
            M_WAIT: begin
                if (ls) model_goto(M_STABLE);
                else if (last) begin
                    model_goto(M_RESET);
                    if (m_retries < 255) m_retries++;
                end else m_elapsed++;
            end
            M_STABLE: if (!ls) model_goto(M_WAIT); else if (last) model_goto(M_HOLD); else m_elapsed++;
            M_HOLD:   if (!ls) model_goto(M_WAIT); else if (last) model_goto(M_RUN);  else m_elapsed++;
            default: begin
                if (!ls) begin
                    model_goto(M_WAIT);
                    if (m_losses < 255) m_losses++;
                end
            end
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic compare_model();
        check("model.state",     32'(state),           32'(int'(m_phase)));
        check("model.pll_rst",   32'(pll_rst),         32'(m_phase == M_RESET));
        check("model.sys_reset", 32'(sys_reset),       32'(m_phase != M_RUN));
        check("model.ready",     32'(ready),           32'(m_phase == M_RUN));
        check("model.retries",   32'(retry_count),     32'(m_retries));
        check("model.losses",    32'(lock_loss_count), 32'(m_losses));
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic tick(input bit lk);
        pll_locked = lk;
        @(posedge clk);
        model_step(lk);
        #1;
        compare_model();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        reset = 1'b0;
    endtask

    initial begin
        bit lvl;
        int run_len;
        bit found;

        reset      = 1'b1;
        pll_locked = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);

        // Values while reset is held.
        check("rst.state",     32'(state),           0);
        check("rst.pll_rst",   32'(pll_rst),         1);
        check("rst.sys_reset", 32'(sys_reset),       1);
        check("rst.ready",     32'(ready),           0);
        check("rst.retries",   32'(retry_count),     0);
        check("rst.losses",    32'(lock_loss_count), 0);

        // Release: pll_rst high for RST edges, then WAIT_LOCK.
        model_reset();
        reset = 1'b0;
        for (int i = 1; i < RSTC; i++) begin
            tick(1'b0);
            check("rel.pll_rst_high", 32'(pll_rst), 1);
        end
        tick(1'b0);
        check("rel.pll_rst_low", 32'(pll_rst), 0);
        check("rel.state_wait",  32'(state),   1);

        // Glitch in STABLE: 5 stable cycles, then a 3-cycle drop hitting the
        // final counting cycle.
        for (int i = 0; i < 3; i++) tick(1'b1);
        check("glitch.in_stable", 32'(state), 2);
        for (int i = 0; i < 5; i++) tick(1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0);
        check("glitch.state_wait", 32'(state),           1);
        check("glitch.sys_reset",  32'(sys_reset),       1);
        check("glitch.losses",     32'(lock_loss_count), 0);

        // Re-lock needs the full latency again: RUN on the 15th edge.
        for (int i = 0; i < 14; i++) tick(1'b1);
        check("relock.not_ready", 32'(ready), 0);
        tick(1'b1);
        check("relock.ready",     32'(ready),           1);
        check("relock.sys_reset", 32'(sys_reset),       0);
        check("relock.state_run", 32'(state),           4);
        check("relock.losses",    32'(lock_loss_count), 0);
        check("relock.retries",   32'(retry_count),     0);

        // Loss in RUN: reaction on the 3rd edge, PLL not reset.
        tick(1'b0);
        tick(1'b0);
        check("loss.still_ready", 32'(ready), 1);
        tick(1'b0);
        check("loss.state",     32'(state),           1);
        check("loss.sys_reset", 32'(sys_reset),       1);
        check("loss.ready",     32'(ready),           0);
        check("loss.count",     32'(lock_loss_count), 1);
        check("loss.pll_rst",   32'(pll_rst),         0);
        for (int i = 0; i < 15; i++) tick(1'b1);
        check("loss.rerun", 32'(state), 4);

        // Randomised lock/unlock runs against the model.
        lvl = 1'b0;
        for (int r = 0; r < 120; r++) begin
            lvl     = ~lvl;
            run_len = (($urandom % 4) == 0) ? int'($urandom_range(15, 30)) : int'($urandom_range(1, 12));
            for (int i = 0; i < run_len; i++) tick(lvl);
        end

        // Timeout retry from a fresh reset.
        do_reset();
        for (int i = 0; i < RSTC; i++) tick(1'b0);
        for (int i = 1; i < TIMEOUT; i++) tick(1'b0);
        check("tmo.pre_pll_rst", 32'(pll_rst),     0);
        check("tmo.pre_retries", 32'(retry_count), 0);
        tick(1'b0);
        check("tmo.pll_rst", 32'(pll_rst),     1);
        check("tmo.retries", 32'(retry_count), 1);
        check("tmo.state",   32'(state),       0);
        for (int i = 1; i < RSTC; i++) tick(1'b0);
        check("tmo.pll_rst_held", 32'(pll_rst), 1);
        tick(1'b0);
        check("tmo.pll_rst_done", 32'(pll_rst), 0);

        // Saturation: 300 more timeouts.
        for (int i = 0; i < 300 * (TIMEOUT + RSTC); i++) tick(1'b0);
        check("sat.retries", 32'(retry_count),     255);
        check("sat.losses",  32'(lock_loss_count), 0);

        // Mid-sequence asynchronous reset while in HOLD.
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick(1'b1);
            if (m_phase == M_HOLD) found = 1'b1;
        end
        check("hold.reached", 32'(found), 1);
        tick(1'b1);
        check("hold.state", 32'(state), 3);
        #5;
        reset = 1'b1;
        #1;
        check("async.state",     32'(state),           0);
        check("async.pll_rst",   32'(pll_rst),         1);
        check("async.sys_reset", 32'(sys_reset),       1);
        check("async.ready",     32'(ready),           0);
        check("async.retries",   32'(retry_count),     0);
        check("async.losses",    32'(lock_loss_count), 0);
        check("async.sync",      32'(dut.sync_q),      0);
        @(posedge clk);
        #1;
        check("async.sync_held",  32'(dut.sync_q), 0);
        check("async.state_held", 32'(state),      0);
        @(negedge clk);
        model_reset();
        reset = 1'b0;
        for (int i = 0; i < RSTC + 15; i++) tick(1'b1);
        check("final.run", 32'(state), 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
